// File: rtl/tm_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tm_seq_mult
//  Purpose  : Sequential radix-2 shift-add unsigned N x N multiplier with a
//             run-time choice between an exact product and a truncated (TM)
//             product. The truncated product drops every partial product
//             a[i]&b[j] with i<K or j<K. That is the same as multiplying the
//             operands pre-shifted right by K and shifting the result left by
//             2K. One retained multiplier bit is consumed per cycle.
//
//  Ports    : clk        clock, rising-edge
//             rst        synchronous reset, active-high
//             in_valid   operands/mode valid
//             in_ready   block can accept operands (IDLE only)
//             a, b       N-bit unsigned operands
//             trunc_en   1 = truncated mode with cut K, 0 = exact
//             out_valid  product valid (DONE)
//             out_ready  consumer accepts product
//             p          2N-bit registered product
//             busy       high in MUL or DONE
//
//  Revision : 1.0  initial release
// ============================================================================
module tm_seq_mult #(
  parameter int N = 8,
  parameter int K = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           trunc_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p,
  output logic           busy
);

  // The counter must hold the value N, the largest iteration count.
  localparam int             CW           = $clog2(N + 1);
  localparam logic [CW-1:0]  c_iter_exact = CW'(N);
  localparam logic [CW-1:0]  c_iter_tm    = CW'(N - K);
  localparam logic [CW-1:0]  c_one        = CW'(1);
  localparam int             c_tm_shift   = 2 * K;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [2*N-1:0]   r_mcand;     // multiplicand, shifted left each MUL cycle
  logic [N-1:0]     r_mplier;    // multiplier, shifted right each MUL cycle
  logic [2*N-1:0]   r_acc;
  logic [CW-1:0]    r_cnt;       // MUL cycles still to run
  logic             r_trunc;     // mode captured on the accepting edge
  logic [2*N-1:0]   r_p;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_busy;

  logic [N-1:0]     w_a_op;
  logic [N-1:0]     w_b_op;
  logic [2*N-1:0]   w_addend;
  logic [2*N-1:0]   w_acc_next;
  logic [2*N-1:0]   w_p_final;

  // Operand conditioning at accept time. In truncated mode the low K bits of
  // each operand only ever feed discarded partial products. Shifting them out
  // up front cuts the iteration count to N-K.
  always_comb begin
    w_a_op = a;
    w_b_op = b;
    if (trunc_en) begin
      w_a_op = a >> K;
      w_b_op = b >> K;
    end
  end

  // One shift-add step. The accumulator is 2N bits wide, so the sum of all
  // partial products of two N-bit operands always fits.
  always_comb begin
    w_addend   = r_mplier[0] ? r_mcand : '0;
    w_acc_next = r_acc + w_addend;
    w_p_final  = w_acc_next;
    if (r_trunc) begin
      // Re-align the reduced product. Bits [2K-1:0] become zero and no carry
      // is invented into the top bit.
      w_p_final = w_acc_next << c_tm_shift;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_trunc     <= 1'b0;
      r_p         <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_mcand    <= {{N{1'b0}}, w_a_op};
            r_mplier   <= w_b_op;
            r_acc      <= '0;
            r_cnt      <= trunc_en ? c_iter_tm : c_iter_exact;
            r_trunc    <= trunc_en;
            r_state    <= ST_MUL;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt - c_one;
          // On the last step, publish the product on this same edge so that
          // out_valid rises exactly I cycles after the accept.
          if (r_cnt == c_one) begin
            r_p         <= w_p_final;
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // p and out_valid hold while the consumer stalls. in_ready stays
          // low, so no new operands can be taken on the handshake edge.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign p         = r_p;

endmodule
`default_nettype wire

// File: tb/tb_tm_seq_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tm_seq_mult
//  Purpose  : Self-checking bench for tm_seq_mult. Three instances (K=7, K=4,
//             K=0, all N=8) share the same stimulus. A cycle-level reference
//             model derives the outputs from the arithmetic definition and the
//             handshake rules. Directed vectors carry hand-computed products.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tm_seq_mult;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             trunc_en = 1'b0;
  logic [7:0]       a = 8'h00;
  logic [7:0]       b = 8'h00;
  logic [2:0]       in_ready_v;
  logic [2:0]       out_valid_v;
  logic [2:0]       busy_v;
  logic [2:0][15:0] p_v;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tm_seq_mult #(.N(8), .K(7)) u_k7 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
    .a(a), .b(b), .trunc_en(trunc_en), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .p(p_v[0]), .busy(busy_v[0]));

  tm_seq_mult #(.N(8), .K(4)) u_k4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
    .a(a), .b(b), .trunc_en(trunc_en), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .p(p_v[1]), .busy(busy_v[1]));

  tm_seq_mult #(.N(8), .K(0)) u_k0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
    .a(a), .b(b), .trunc_en(trunc_en), .out_valid(out_valid_v[2]),
    .out_ready(out_ready), .p(p_v[2]), .busy(busy_v[2]));

  // ---------------------------------------------------------------- model
  function automatic int kof(input int i);
    return (i == 0) ? 7 : ((i == 1) ? 4 : 0);
  endfunction

  function automatic logic [15:0] model_prod(input logic [7:0] x, input logic [7:0] y,
                                             input logic tm, input int k);
    int xx;
    int yy;
    int r;
    xx = tm ? (int'(x) >> k) : int'(x);
    yy = tm ? (int'(y) >> k) : int'(y);
    r  = (xx * yy) << (tm ? 2 * k : 0);
    return r[15:0];
  endfunction

  // phase: 0 waiting for operands, 1 computing, 2 holding result
  int          ph   [3] = '{0, 0, 0};
  int          left [3] = '{0, 0, 0};
  logic [15:0] res  [3];
  logic [15:0] mp   [3] = '{16'h0, 16'h0, 16'h0};
  bit          pk   [3] = '{1'b0, 1'b0, 1'b0};   // p value is defined

  task automatic chk(input string nm, input int i, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, i, $time, got, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        ph[i] = 0;
        mp[i] = 16'h0;
        pk[i] = 1'b1;
      end else begin
        case (ph[i])
          0: if (in_valid) begin
               left[i] = trunc_en ? 8 - kof(i) : 8;
               res[i]  = model_prod(a, b, trunc_en, kof(i));
               ph[i]   = 1;
               pk[i]   = 1'b0;
             end
          1: begin
               left[i] = left[i] - 1;
               if (left[i] == 0) begin
                 ph[i] = 2;
                 mp[i] = res[i];
                 pk[i] = 1'b1;
               end
             end
          default: if (out_ready) begin
               ph[i] = 0;
               pk[i] = 1'b0;
             end
        endcase
      end
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("in_ready",  i, {15'h0, in_ready_v[i]},  {15'h0, ph[i] == 0});
      chk("out_valid", i, {15'h0, out_valid_v[i]}, {15'h0, ph[i] == 2});
      chk("busy",      i, {15'h0, busy_v[i]},      {15'h0, ph[i] != 0});
      if (pk[i]) chk("p_model", i, p_v[i], mp[i]);
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic run(input logic [7:0] ta, input logic [7:0] tb, input logic tt,
                     input int hold, input bit lit,
                     input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    int cnt;
    @(negedge clk);
    a = ta; b = tb; trunc_en = tt; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    // Operands wiggle during MUL; the captured values must be the ones used.
    while (out_valid_v != 3'b111 && cnt < 40) begin
      a = 8'($urandom); b = 8'($urandom); trunc_en = 1'($urandom);
      @(negedge clk);
      cnt++;
    end
    if (out_valid_v != 3'b111) begin
      checks++;
      failures++;
      $display("FAIL timeout out_valid got=%b exp=111", out_valid_v);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    repeat (hold) @(negedge clk);
    if (lit) begin
      chk("p_lit", 0, p_v[0], e0);
      chk("p_lit", 1, p_v[1], e1);
      chk("p_lit", 2, p_v[2], e2);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready",  0, {13'h0, in_ready_v},  16'h0007);
    chk("rst_out_valid", 0, {13'h0, out_valid_v}, 16'h0000);
    chk("rst_busy",      0, {13'h0, busy_v},      16'h0000);
    for (int i = 0; i < 3; i++) chk("rst_p", i, p_v[i], 16'h0000);

    //   a      b     tm   hold lit   K=7       K=4       K=0
    run(8'hFF, 8'hFF, 1'b1, 0, 1'b1, 16'h4000, 16'hE100, 16'hFE01);
    run(8'h7F, 8'hFF, 1'b1, 0, 1'b1, 16'h0000, 16'h6900, 16'h7E81);
    run(8'hFF, 8'hFF, 1'b0, 0, 1'b1, 16'hFE01, 16'hFE01, 16'hFE01);
    run(8'h00, 8'h55, 1'b0, 0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    run(8'hA5, 8'h3C, 1'b1, 0, 1'b1, 16'h0000, 16'h1E00, 16'h26AC);
    run(8'hA5, 8'h3C, 1'b0, 5, 1'b1, 16'h26AC, 16'h26AC, 16'h26AC);
    run(8'h80, 8'h80, 1'b1, 2, 1'b1, 16'h4000, 16'h4000, 16'h4000);
    run(8'hC3, 8'h91, 1'b1, 0, 1'b1, 16'h4000, 16'h6C00, 16'h6E73);
    run(8'hC3, 8'h91, 1'b0, 1, 1'b1, 16'h6E73, 16'h6E73, 16'h6E73);

    // Reset on the third MUL edge of an exact multiply.
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; trunc_en = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready",  0, {13'h0, in_ready_v},  16'h0007);
    chk("mid_rst_out_valid", 0, {13'h0, out_valid_v}, 16'h0000);
    chk("mid_rst_busy",      0, {13'h0, busy_v},      16'h0000);
    for (int i = 0; i < 3; i++) chk("mid_rst_p", i, p_v[i], 16'h0000);
    run(8'h03, 8'h05, 1'b0, 0, 1'b1, 16'h000F, 16'h000F, 16'h000F);

    // Random operand pairs in both modes; checked by the cycle model.
    for (int n = 0; n < 1000; n++) begin
      run(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
          1'b0, 16'h0, 16'h0, 16'h0);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tm_seq_mult.md
Name: tm_seq_mult

Overview:
- Parametrised, sequential, handshaked successor to the team's fixed-size combinational truncated multipliers.
- Computes an unsigned N x N product with run-time selection between exact mode and truncated (TM) mode; truncation cut K is set at elaboration.
- TM mode discards every partial product a[i]&b[j] with i<K or j<K.
- Radix-2 shift-add datapath; one retained multiplier bit per cycle; trades latency for area in approximate-arithmetic accelerators.

Parameters:
- N, 8, operand width in bits; N >= 2.
- K, 7, truncation cut; 0 <= K <= N-1; K=0 makes TM mode equal to exact mode.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operands and mode valid.
- in_ready  output  1  block can accept operands.
- a  input  N  multiplicand, unsigned.
- b  input  N  multiplier, unsigned.
- trunc_en  input  1  1 = TM mode with cut K; 0 = exact mode; sampled on accept.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- p  output  2N  product.
- busy  output  1  high in MUL or DONE states.

Behaviour:
- Arithmetic:
  - Exact mode: p = a*b.
  - TM mode: p = ((a>>K)*(b>>K)) << 2K, as a 2N-bit result.
  - TM-mode p bits [2K-1:0] are always 0.
  - TM-mode p[2N-1] is whatever the arithmetic yields, with no carry fabrication. For N=8, K=7 this gives p = (a[7]&b[7]) << 14 and p[15] = 0.
- Iteration count I: N-K in TM mode, N in exact mode.
- FSM: IDLE, MUL, DONE.
  - IDLE: in_ready=1. When in_valid is high at an edge, capture operands; in TM mode pre-shift them right by K. Also capture trunc_en, clear the accumulator, load the iteration counter with I, and go to MUL.
  - MUL: in_ready=0. Each edge adds the shifted multiplicand to the accumulator if the current multiplier LSB is 1, then shifts and decrements the counter. After the I-th MUL edge, go to DONE.
  - DONE: out_valid=1. p holds the final value, shifted left by 2K in TM mode. When out_ready is high at an edge, go to IDLE.
- Latency: out_valid rises exactly I cycles after the accepting edge (N=8, K=7: TM 1 cycle, exact 8 cycles). Input-side throughput is one product per I+2 cycles minimum.
- Backpressure: while in DONE with out_ready=0, p and out_valid hold stable indefinitely and in_ready stays 0.
- No accept while in DONE: in_ready is only high in IDLE, so an output handshake and a new input acceptance never happen on the same edge.
- Inputs a, b and trunc_en are ignored outside the accepting edge. Changes during MUL have no effect.
- Accumulator width is 2N; no overflow is possible.
- Reset:
  - Values: state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, counter=0.
  - rst overrides everything, including mid-MUL and a pending DONE; the in-flight result is discarded.
  - The first accept is possible on the first edge after rst deasserts.
- p is registered. Its value outside DONE is undefined to consumers but must not be X after reset.

Test Plan:
- Default params, TM: a=0xFF, b=0xFF, trunc_en=1 -> out_valid 1 cycle after accept, p=0x4000. Then a=0x7F, b=0xFF -> p=0x0000.
- Default params, exact: a=0xFF, b=0xFF, trunc_en=0 -> out_valid 8 cycles after accept, p=0xFE01. Then a=0, b=0x55 -> p=0x0000.
- N=8, K=4: a=0xFF, b=0xFF, trunc_en=1 -> p=0xE100, latency 4. With trunc_en=0 -> p=0xFE01, latency 8. Randomised 1000 operand pairs match the golden model in both modes.
- Backpressure: out_ready=0 for 5 cycles in DONE -> p stable, out_valid=1, in_ready=0. Change a/b during MUL -> result unaffected.
- Reset mid-operation: assert rst on the 3rd MUL cycle of an exact multiply -> next cycle state=IDLE, out_valid=0, p=0, in_ready=1. A fresh a=0x03, b=0x05 exact -> p=0x000F.
- K=0 corner: TM and exact results are identical for a=0xA5, b=0x3C (p=0x26AC), both with latency 8.
